synth_chan_regs: RTL and testbench
==================================

# synth_chan_regs

Memory-mapped multi-channel oscillator control bank on the PicoSoC iomem bus. It replaces the single ad-hoc frequency register with NUM_CH channels, each with a phase increment, a gain and an enable. Software writes shadow registers and then commits them. The commit is applied atomically on the next audio sample boundary, which is the rising edge of DACLRC synchronised into `clk`, so the sine generators never see a half-updated channel set.

## Interface
- NUM_CH, 4: oscillator channels, 1..16
- PHASE_SIZE, 32: phase-increment width, ≤32
- GAIN_W, 8: gain width, ≤16
- BASE_PAGE, 8'h04: iomem_addr[31:24] decoded by this block

Ports:
- clk  in  1  system clock (12 MHz SoC clock)
- reset  in  1  synchronous, active-high
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- lrclk  in  1  asynchronous DACLRC from the codec
- freq_o  out  NUM_CH*PHASE_SIZE  active phase increments, channel 0 in the LSBs
- gain_o  out  NUM_CH*GAIN_W  active gains
- en_o  out  NUM_CH  active enables
- sample_tick  out  1  one-cycle pulse per sample

## Operation
- Decode: the block is selected when iomem_valid, !iomem_ready and iomem_addr[31:24]==BASE_PAGE. An unselected page gets no response and leaves iomem_rdata unchanged.
- Word offset addr[11:2]:
  - 16*c+0 (byte 0x40*c): FREQ[c], PHASE_SIZE bits
  - 16*c+1: {en at bit 31, gain at bits GAIN_W-1:0}
  - 0x3C0 (byte 0xF00) COMMIT: any write sets `pending`; reads return 0
  - 0x3C1 STATUS: read {pending at bit 31, NUM_CH at bits 20:16}; writes ignored
  - 0x3C2 SAMPLES: 32-bit sample counter; read-only
- Unmapped offsets and channels ≥ NUM_CH: reads return 0, writes are ignored, and the access is still acknowledged.
- Writes honour the byte strobes. Bits above PHASE_SIZE or GAIN_W are dropped and read back as 0.
- Reads return shadow values, not active values.
- Tick: lrclk passes through a 2-FF synchroniser, then a rising-edge detect, to produce sample_tick. The sample counter increments on each tick and wraps from 2^32-1 to 0.
- Apply: on a sample_tick with pending=1, every active register takes its shadow value in the same cycle, and pending clears.

## Timing
- Reset values: iomem_ready=0, iomem_rdata=0, all shadow and active registers 0, freq_o=0, gain_o=0, en_o=0, pending=0, counter=0, sample_tick=0, synchroniser flops 0.
- Acknowledge: iomem_ready=1 exactly one cycle after selection, then 0. Back-to-back accesses take at least 2 cycles each.
- Write effect: a shadow register updates on the cycle iomem_ready rises.
- Tick latency: sample_tick pulses 3 clk edges after the lrclk rising edge (2 sync flops plus the edge flop).
- Apply latency: the outputs change on the clk edge that ends the tick cycle.
- COMMIT write and tick in the same cycle: pending is set and that tick does not apply. Application waits for the next tick.
- Shadow write and apply in the same cycle: active takes the pre-write shadow value. The new value needs another commit.
- Repeated commits before a tick collapse into one apply.
- Reset asserted mid-operation: all state returns to the reset values on the next edge, and any pending commit is discarded.
- If lrclk is static, no ticks occur and the outputs hold indefinitely.

## Configuration
- `SYNTH_CHAN_REGS_IRQ_EN` defined:
  - Adds output `irq` (1 bit, reset 0).
  - irq pulses for exactly one cycle, on the cycle after an apply.
  - The top level routes irq to irq_5.
- Macro undefined: no irq port, no extra logic.

## Structure
- Package `synth_pkg`: register word offsets (COMMIT, STATUS, SAMPLES, channel stride 16), default PHASE_SIZE and GAIN_W, and the macro for computing a phase increment from a frequency.
- Sub-module `lrclk_tick`: 2-FF synchroniser plus rising-edge detect, outputs sample_tick. It is reused by future I2S-side blocks.
- Shadow and active registers are flat packed vectors. The channel loop is a generate.

## Test plan
- Reset: hold reset for 4 cycles → freq_o=0, en_o=0, iomem_ready=0, STATUS read returns 32'h0004_0000.
- Register read-back:
  - Write FREQ[2]=32'h0147_AE14 with wstrb=4'hF → ready 1 cycle later. Read returns 32'h0147_AE14. freq_o is unchanged.
  - Write the gain word with wstrb=4'h1 → only gain bits 7:0 change.
- Commit on tick: write COMMIT, then toggle lrclk high → pending=1 until the tick. freq_o[95:64]=32'h0147_AE14 on the edge 3 clk after lrclk rises. STATUS bit 31 reads 0 afterwards.
- Commit/tick collision: issue the COMMIT write in the same cycle as sample_tick → no apply on that tick, apply on the next tick.
- Decode and wrap:
  - Access on page 8'h03 → no ready from this block.
  - Write channel 7 with NUM_CH=4 → acknowledged, reads 0.
  - Preload 2^32-1 via a test force, then one tick → SAMPLES reads 0.
- IRQ (macro defined): commit then tick → irq high for exactly 1 cycle, on the cycle after the apply.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared definitions for the oscillator control bank.
//   - register word offsets (addr[11:2]) and the per-channel stride
//   - default phase-increment and gain widths
//   - register-select enum used by the bus decoder
//   - byte-strobe merge helper for 32-bit bus writes
//   - SYNTH_PHASE_INC(f_hz, fs_hz, w): phase increment for an output
//     frequency f_hz at sample rate fs_hz with a w-bit phase accumulator
`ifndef SYNTH_PKG_SV
`define SYNTH_PKG_SV
`define SYNTH_PHASE_INC(f_hz, fs_hz, w) ((64'(f_hz) << (w)) / 64'(fs_hz))
`endif

package synth_pkg;

  localparam int PHASE_SIZE_DEF = 32;
  localparam int GAIN_W_DEF     = 8;

  // Channel c owns word offsets 16*c .. 16*c+15; only +0 and +1 are mapped.
  localparam int         CH_STRIDE   = 16;
  localparam logic [3:0] SUB_FREQ    = 4'd0;
  localparam logic [3:0] SUB_GAIN    = 4'd1;
  localparam logic [9:0] OFF_COMMIT  = 10'h3C0;
  localparam logic [9:0] OFF_STATUS  = 10'h3C1;
  localparam logic [9:0] OFF_SAMPLES = 10'h3C2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_FREQ,
    REG_GAIN,
    REG_COMMIT,
    REG_STATUS,
    REG_SAMPLES
  } reg_sel_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lrclk_tick.sv
// lrclk_tick: brings the codec DACLRC into the clk domain and emits a
// one-cycle sample_tick per rising edge of lrclk.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   lrclk       in   asynchronous DACLRC
//   sample_tick out  one-cycle pulse, 3 clk edges after lrclk rises
module lrclk_tick (
  input  logic clk,
  input  logic reset,
  input  logic lrclk,
  output logic sample_tick
);

  logic sync1_q, sync2_q, prev_q, tick_q;
  logic sync1_d, sync2_d, prev_d, tick_d;

  always_comb begin
    sync1_d = lrclk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

endmodule

// File: rtl/synth_chan_regs.sv
// synth_chan_regs: NUM_CH-channel oscillator control bank on the PicoSoC
// iomem bus. Software writes shadow registers, then writes COMMIT; the whole
// shadow set is copied into the active registers on the next sample_tick.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   iomem_valid/ready     bus request / one-cycle acknowledge
//   iomem_wstrb           byte strobes, 0 = read
//   iomem_addr/wdata      byte address / write data
//   iomem_rdata           read data, valid while iomem_ready=1
//   lrclk                 asynchronous DACLRC
//   freq_o, gain_o, en_o  active channel registers, channel 0 in the LSBs
//   sample_tick           one-cycle pulse per audio sample
//   irq                   only with SYNTH_CHAN_REGS_IRQ_EN defined: one-cycle
//                         pulse on the cycle after an apply (routed to irq_5)
module synth_chan_regs
  import synth_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         PHASE_SIZE = PHASE_SIZE_DEF,
  parameter int         GAIN_W     = GAIN_W_DEF,
  parameter logic [7:0] BASE_PAGE  = 8'h04
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iomem_valid,
  output logic                         iomem_ready,
  input  logic [3:0]                   iomem_wstrb,
  input  logic [31:0]                  iomem_addr,
  input  logic [31:0]                  iomem_wdata,
  output logic [31:0]                  iomem_rdata,
  input  logic                         lrclk,
  output logic [NUM_CH*PHASE_SIZE-1:0] freq_o,
  output logic [NUM_CH*GAIN_W-1:0]     gain_o,
  output logic [NUM_CH-1:0]            en_o,
  output logic                         sample_tick
`ifdef SYNTH_CHAN_REGS_IRQ_EN
  ,
  output logic                         irq
`endif
);

  logic [NUM_CH*PHASE_SIZE-1:0] freq_sh_q, freq_sh_d, freq_act_q, freq_act_d;
  logic [NUM_CH*GAIN_W-1:0]     gain_sh_q, gain_sh_d, gain_act_q, gain_act_d;
  logic [NUM_CH-1:0]            en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic                         pending_q, pending_d;
  logic [31:0]                  smp_cnt_q, smp_cnt_d;
  logic                         ready_q, ready_d;
  logic [31:0]                  rdata_q, rdata_d;

  logic [9:0]  woff;
  logic [5:0]  ch;
  logic [3:0]  sub;
  logic        sel, wr, commit_wr, apply;
  reg_sel_e    rsel;
  logic [31:0] rd_word;
  logic [31:0] fword [NUM_CH];
  logic [31:0] gword [NUM_CH];
  logic        unused_addr;

  lrclk_tick u_tick (
    .clk         (clk),
    .reset       (reset),
    .lrclk       (lrclk),
    .sample_tick (sample_tick)
  );

  assign unused_addr = ^{iomem_addr[23:12], iomem_addr[1:0]};

  assign woff = iomem_addr[11:2];
  assign ch   = 6'(woff / 10'(CH_STRIDE));
  assign sub  = 4'(woff % 10'(CH_STRIDE));
  // !ready_q keeps a held request from being serviced twice back to back.
  assign sel  = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_PAGE);
  assign wr   = sel && (iomem_wstrb != 4'h0);

  always_comb begin
    rsel = REG_NONE;
    if (woff == OFF_COMMIT)                        rsel = REG_COMMIT;
    else if (woff == OFF_STATUS)                   rsel = REG_STATUS;
    else if (woff == OFF_SAMPLES)                  rsel = REG_SAMPLES;
    else if (int'(ch) < NUM_CH && sub == SUB_FREQ) rsel = REG_FREQ;
    else if (int'(ch) < NUM_CH && sub == SUB_GAIN) rsel = REG_GAIN;
  end

  assign commit_wr = wr && (rsel == REG_COMMIT);
  // A commit landing on the tick cycle defers the apply to the next tick.
  assign apply = sample_tick && pending_q && !commit_wr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0] f_new, g_new;
    logic        hit_f, hit_g;
    logic        unused_g;

    assign fword[c] = 32'(freq_sh_q[c*PHASE_SIZE +: PHASE_SIZE]);
    assign gword[c] = {en_sh_q[c], 31'(gain_sh_q[c*GAIN_W +: GAIN_W])};
    assign f_new    = byte_merge(fword[c], iomem_wdata, iomem_wstrb);
    assign g_new    = byte_merge(gword[c], iomem_wdata, iomem_wstrb);
    assign unused_g = ^g_new[30:GAIN_W];
    assign hit_f    = wr && (rsel == REG_FREQ) && (int'(ch) == c);
    assign hit_g    = wr && (rsel == REG_GAIN) && (int'(ch) == c);

    assign freq_sh_d[c*PHASE_SIZE +: PHASE_SIZE] =
      hit_f ? f_new[PHASE_SIZE-1:0] : freq_sh_q[c*PHASE_SIZE +: PHASE_SIZE];
    assign gain_sh_d[c*GAIN_W +: GAIN_W] =
      hit_g ? g_new[GAIN_W-1:0] : gain_sh_q[c*GAIN_W +: GAIN_W];
    assign en_sh_d[c] = hit_g ? g_new[31] : en_sh_q[c];
  end

  always_comb begin
    rd_word = '0;
    case (rsel)
      REG_FREQ: begin
        for (int c = 0; c < NUM_CH; c++) if (int'(ch) == c) rd_word = fword[c];
      end
      REG_GAIN: begin
        for (int c = 0; c < NUM_CH; c++) if (int'(ch) == c) rd_word = gword[c];
      end
      REG_STATUS:  rd_word = {pending_q, 10'd0, 5'(NUM_CH), 16'd0};
      REG_SAMPLES: rd_word = smp_cnt_q;
      default:     rd_word = '0;
    endcase
  end

  always_comb begin
    // Active registers always load the pre-write shadow set.
    freq_act_d = apply ? freq_sh_q : freq_act_q;
    gain_act_d = apply ? gain_sh_q : gain_act_q;
    en_act_d   = apply ? en_sh_q   : en_act_q;
    pending_d  = commit_wr ? 1'b1 : (apply ? 1'b0 : pending_q);
    smp_cnt_d  = sample_tick ? smp_cnt_q + 32'd1 : smp_cnt_q;
    ready_d    = sel;
    rdata_d    = sel ? rd_word : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_sh_q  <= '0;
      gain_sh_q  <= '0;
      en_sh_q    <= '0;
      freq_act_q <= '0;
      gain_act_q <= '0;
      en_act_q   <= '0;
      pending_q  <= 1'b0;
      smp_cnt_q  <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      freq_sh_q  <= freq_sh_d;
      gain_sh_q  <= gain_sh_d;
      en_sh_q    <= en_sh_d;
      freq_act_q <= freq_act_d;
      gain_act_q <= gain_act_d;
      en_act_q   <= en_act_d;
      pending_q  <= pending_d;
      smp_cnt_q  <= smp_cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef SYNTH_CHAN_REGS_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = apply;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign freq_o      = freq_act_q;
  assign gain_o      = gain_act_q;
  assign en_o        = en_act_q;

endmodule

// File: tb/tb_synth_chan_regs.sv
// Testbench for synth_chan_regs: directed scenarios plus a randomized
// bus/tick sequence, checked against a register-level model kept as plain
// arrays (shadow set, active set, pending flag, sample count).
module tb_synth_chan_regs;

  localparam int NUM_CH = 4;
  localparam int PS     = 32;
  localparam int GW     = 8;

  logic                 clk, reset;
  logic                 iomem_valid, iomem_ready;
  logic [3:0]           iomem_wstrb;
  logic [31:0]          iomem_addr, iomem_wdata, iomem_rdata;
  logic                 lrclk, sample_tick;
  logic [NUM_CH*PS-1:0] freq_o;
  logic [NUM_CH*GW-1:0] gain_o;
  logic [NUM_CH-1:0]    en_o;
`ifdef SYNTH_CHAN_REGS_IRQ_EN
  logic                 irq;
`endif

  synth_chan_regs #(.NUM_CH(NUM_CH), .PHASE_SIZE(PS), .GAIN_W(GW), .BASE_PAGE(8'h04)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .lrclk       (lrclk),
    .freq_o      (freq_o),
    .gain_o      (gain_o),
    .en_o        (en_o),
    .sample_tick (sample_tick)
`ifdef SYNTH_CHAN_REGS_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_sh_freq  [NUM_CH];
  logic [7:0]  m_sh_gain  [NUM_CH];
  logic        m_sh_en    [NUM_CH];
  logic [31:0] m_act_freq [NUM_CH];
  logic [7:0]  m_act_gain [NUM_CH];
  logic        m_act_en   [NUM_CH];
  logic        m_pend;
  logic [31:0] m_count;
  logic [31:0] last_rd;
  bit          last_known;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] st);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ra(input int w);
    return {8'h04, 12'h000, 10'(w), 2'b00};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh_freq[c] = '0; m_sh_gain[c] = '0; m_sh_en[c] = 1'b0;
      m_act_freq[c] = '0; m_act_gain[c] = '0; m_act_en[c] = 1'b0;
    end
    m_pend = 1'b0;
    m_count = '0;
    last_rd = '0;
    last_known = 1'b1;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w, c, s;
    w = int'(a[11:2]);
    c = w / 16;
    s = w % 16;
    if (w == 'h3C1) return {m_pend, 10'd0, 5'(NUM_CH), 16'd0};
    if (w == 'h3C2) return m_count;
    if (w == 'h3C0) return 32'd0;
    if (c < NUM_CH && s == 0) return m_sh_freq[c];
    if (c < NUM_CH && s == 1) return {m_sh_en[c], 23'd0, m_sh_gain[c]};
    return 32'd0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int w, c, s;
    logic [31:0] word;
    w = int'(a[11:2]);
    c = w / 16;
    s = w % 16;
    if (w == 'h3C0) m_pend = 1'b1;
    else if (c < NUM_CH && s == 0) m_sh_freq[c] = bmerge(m_sh_freq[c], d, st);
    else if (c < NUM_CH && s == 1) begin
      word = bmerge({m_sh_en[c], 23'd0, m_sh_gain[c]}, d, st);
      m_sh_en[c]   = word[31];
      m_sh_gain[c] = word[7:0];
    end
  endtask

  // Sample tick: copy shadow to active when a commit is pending.
  task automatic m_tick(input bit commit_same_cycle);
    if (m_pend && !commit_same_cycle) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_act_freq[c] = m_sh_freq[c];
        m_act_gain[c] = m_sh_gain[c];
        m_act_en[c]   = m_sh_en[c];
      end
      m_pend = 1'b0;
    end
    m_count = m_count + 32'd1;
  endtask

  task automatic chk_outs(input string tag);
    logic [NUM_CH*PS-1:0] ef;
    logic [NUM_CH*GW-1:0] eg;
    logic [NUM_CH-1:0]    ee;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c*PS +: PS] = m_act_freq[c];
      eg[c*GW +: GW] = m_act_gain[c];
      ee[c]          = m_act_en[c];
    end
    chk({tag, "_freq"}, freq_o, ef);
    chk({tag, "_gain"}, gain_o, eg);
    chk({tag, "_en"}, en_o, ee);
  endtask

  // One bus access: request in one cycle, acknowledge expected in the next.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] exp_rd;
    bit hit;
    hit    = (a[31:24] == 8'h04);
    exp_rd = m_read(a);
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = st;
    @(negedge clk);
    chk("ack", iomem_ready, hit);
    if (hit && st == 4'h0) chk("rdata", iomem_rdata, exp_rd);
    if (!hit && last_known) chk("rdata_hold", iomem_rdata, last_rd);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    if (hit && st != 4'h0) begin
      m_write(a, d, st);
      last_known = 1'b0;
    end
    if (hit && st == 4'h0) begin
      last_rd = exp_rd;
      last_known = 1'b1;
    end
    @(negedge clk);
    chk("ack_drop", iomem_ready, 1'b0);
  endtask

  task automatic do_tick();
    bit ap;
    @(negedge clk); lrclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tick_early", sample_tick, 1'b0);
    @(negedge clk);
    chk("tick", sample_tick, 1'b1);
    chk_outs("pre_apply");
    ap = m_pend;
    m_tick(1'b0);
    @(negedge clk);
    chk("tick_end", sample_tick, 1'b0);
    chk_outs("post_apply");
`ifdef SYNTH_CHAN_REGS_IRQ_EN
    chk("irq", irq, ap);
`endif
    @(negedge clk); lrclk = 1'b0;
`ifdef SYNTH_CHAN_REGS_IRQ_EN
    chk("irq_end", irq, 1'b0);
`endif
    if (ap) begin end
    repeat (4) @(negedge clk);
  endtask

  // Tick whose cycle coincides with the selection cycle of a write.
  task automatic tick_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    bit is_commit;
    is_commit = (a[11:2] == 10'h3C0) && (st != 4'h0);
    @(negedge clk); lrclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_tick(is_commit);
    bus(a, d, st);
    lrclk = 1'b0;
    repeat (4) @(negedge clk);
    chk_outs("tick_access");
  endtask

  initial begin
    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = '0; iomem_wdata = '0; lrclk = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_ready", iomem_ready, 1'b0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_tick", sample_tick, 1'b0);
    chk_outs("rst");
    reset = 1'b0;
    bus(ra('h3C1), 0, 4'h0);
    chk("status_rst", last_rd, 32'h0004_0000);

    // Read-back, strobes, commit on tick
    bus(ra(32), 32'h0147_AE14, 4'hF);
    bus(ra(32), 0, 4'h0);
    chk_outs("no_commit");
    bus(ra(33), 32'hFFFF_FFA5, 4'h1);
    bus(ra(33), 0, 4'h0);
    bus(ra(33), 32'h8000_0000, 4'h8);
    bus(ra(33), 0, 4'h0);
    bus(ra('h3C0), 32'h1, 4'hF);
    bus(ra('h3C1), 0, 4'h0);
    do_tick();
    chk("freq2", freq_o[95:64], 32'h0147_AE14);
    bus(ra('h3C1), 0, 4'h0);

    // Commit colliding with a tick is deferred
    bus(ra(32), 32'h1234_5678, 4'hF);
    tick_access(ra('h3C0), 32'h1, 4'hF);
    chk("collide_hold", freq_o[95:64], 32'h0147_AE14);
    do_tick();
    chk("collide_apply", freq_o[95:64], 32'h1234_5678);

    // Shadow write on the apply cycle: active takes the old shadow
    bus(ra(16), 32'hAAAA_0001, 4'hF);
    bus(ra('h3C0), 32'h0, 4'h2);
    tick_access(ra(16), 32'h5555_0002, 4'hF);
    chk("old_shadow", freq_o[63:32], 32'hAAAA_0001);
    bus(ra(16), 0, 4'h0);

    // Repeated commits collapse into one apply
    bus(ra('h3C0), 1, 4'hF);
    bus(ra('h3C0), 1, 4'hF);
    do_tick();
    do_tick();

    // Unmapped channel and foreign page
    bus(ra(7*16), 32'hFFFF_FFFF, 4'hF);
    bus(ra(7*16), 0, 4'h0);
    bus(ra('h3C1), 0, 4'h0);
    bus({8'h03, 24'h000F04}, 0, 4'h0);
    bus({8'h03, 24'h000080}, 32'hDEAD_BEEF, 4'hF);

    // Static lrclk: outputs hold
    repeat (20) @(negedge clk);
    chk("static_tick", sample_tick, 1'b0);
    chk_outs("static");

    // Sample counter wrap
    @(negedge clk);
    force dut.smp_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.smp_cnt_q;
    m_count = 32'hFFFF_FFFF;
    bus(ra('h3C2), 0, 4'h0);
    do_tick();
    bus(ra('h3C2), 0, 4'h0);
    chk("wrap", last_rd, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int op, c;
      c  = $urandom_range(0, 7);
      op = $urandom_range(0, 5);
      case (op)
        0: bus(ra(16*c), $urandom, 4'($urandom_range(1, 15)));
        1: bus(ra(16*c + 1), $urandom, 4'($urandom_range(1, 15)));
        2: begin
          case ($urandom_range(0, 2))
            0: bus(ra(16*c + $urandom_range(0, 3)), 0, 4'h0);
            1: bus(ra('h3C1), 0, 4'h0);
            default: bus(ra('h3C2), 0, 4'h0);
          endcase
          bus({8'h03, 24'($urandom)}, 0, 4'h0);
        end
        3: bus(ra('h3C0), $urandom, 4'hF);
        4: do_tick();
        default: begin
          if ($urandom_range(0, 1) == 1) tick_access(ra('h3C0), 32'h1, 4'hF);
          else tick_access(ra(16*c), $urandom, 4'hF);
        end
      endcase
    end
    chk_outs("rand_end");

    // Reset mid-operation discards a pending commit
    bus(ra(0), 32'hCAFE_F00D, 4'hF);
    bus(ra(1), 32'h8000_00FF, 4'hF);
    bus(ra('h3C0), 1, 4'hF);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    m_reset();
    chk_outs("midrst");
    chk("midrst_ready", iomem_ready, 1'b0);
    bus(ra('h3C1), 0, 4'h0);
    chk("midrst_status", last_rd, 32'h0004_0000);
    do_tick();
    chk_outs("midrst_tick");
    bus(ra('h3C2), 0, 4'h0);
    bus(ra(0), 0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
